// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) with internal HI/LO; MD_EARLY_TERM_EN enables multiply early exit.
// Latency: WIDTH+1 edges from accepted start to done (divide-by-zero: 1 edge); early exit shortens multiplies to as few as 2.
// Backpressure: start is only sampled while idle; pulses while busy are dropped without effect.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;      // multiply: product; divide: partial remainder in low half
    logic [2*WIDTH-1:0]   opA;      // multiply: shifted multiplicand; divide: dividend/quotient in low half
    logic [WIDTH-1:0]     opB;      // multiply: remaining multiplier; divide: divisor
    logic                 isDiv;
    logic                 negHi;
    logic                 negLo;

    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH:0]       remShift;
    logic [WIDTH:0]       remDiff;
    logic                 lastIter;

    always_comb begin
        magA     = (sgn && a[WIDTH-1]) ? -a : a;
        magB     = (sgn && b[WIDTH-1]) ? -b : b;
        remShift = {acc[WIDTH-1:0], opA[WIDTH-1]};
        remDiff  = remShift - {1'b0, opB};
        lastIter = (count == CNT_W'(WIDTH - 1));
`ifdef MD_EARLY_TERM_EN
        // Multiplicand is pre-shifted, so the product is already aligned when the multiplier runs out.
        if (!isDiv && (opB[WIDTH-1:1] == '0))
            lastIter = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            opA   <= '0;
            opB   <= '0;
            isDiv <= 1'b0;
            negHi <= 1'b0;
            negLo <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            div0 <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            isDiv <= op;
                            acc   <= '0;
                            opA   <= {{WIDTH{1'b0}}, magA};
                            opB   <= magB;
                            negLo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            // Remainder follows the dividend; a product sign applies to both halves.
                            negHi <= op ? (sgn && a[WIDTH-1]) : (sgn && (a[WIDTH-1] ^ b[WIDTH-1]));
                            count <= '0;
                            div0  <= 1'b0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (isDiv) begin
                        acc <= {{WIDTH{1'b0}}, (remDiff[WIDTH] ? remShift[WIDTH-1:0] : remDiff[WIDTH-1:0])};
                        opA <= {opA[2*WIDTH-2:0], ~remDiff[WIDTH]};
                    end else begin
                        if (opB[0])
                            acc <= acc + opA;
                        opA <= opA << 1;
                        opB <= opB >> 1;
                    end
                    if (lastIter)
                        state <= FIX;
                end
                FIX: begin
                    if (isDiv) begin
                        lo <= negLo ? -opA[WIDTH-1:0] : opA[WIDTH-1:0];
                        hi <= negHi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= negLo ? -acc : acc;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32: results, latency, busy, divide-by-zero, ignored starts, mid-op reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int assertCount = 0;
    int failCount   = 0;
    int edges, busyLow;
    int earlyLat;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assertCount++;
        if (obs !== expv) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Called #1 after an edge; edge k is the next rising edge. Returns edges from k to done.
    task automatic runOp(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input int noiseAt, output int lat, output int bLow);
        start = 1'b1; op = o; sgn = s; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = -1;
        bLow = 0;
        for (int n = 1; n <= 100; n++) begin
            if (!busy) bLow++;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (n == noiseAt) begin
                start = 1'b1; op = 1'b1; a = '0; b = '0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (lat < 0) checkEq("done_timeout", 64'(lat), 64'd0);
    endtask

    initial begin
`ifdef MD_EARLY_TERM_EN
        earlyLat = 2;
`else
        earlyLat = 33;
`endif
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst_busy", 64'(busy), 64'd0);
        checkEq("rst_done", 64'(done), 64'd0);
        checkEq("rst_div0", 64'(div0), 64'd0);
        checkEq("rst_hi", 64'(hi), 64'd0);
        checkEq("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        runOp(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, edges, busyLow);
        checkEq("umul_hi", 64'(hi), 64'hFFFFFFFE);
        checkEq("umul_lo", 64'(lo), 64'h00000001);
        checkEq("umul_lat", 64'(edges), 64'd33);
        checkEq("umul_busy", 64'(busyLow), 64'd0);
        checkEq("umul_busy_end", 64'(busy), 64'd0);

        // Started while done is high; a div-by-zero start pulse is injected mid-operation.
        runOp(1'b0, 1'b1, 32'hFFFFFFF9, 32'd6, 5, edges, busyLow);
        checkEq("smul_hi", 64'(hi), 64'hFFFFFFFF);
        checkEq("smul_lo", 64'(lo), 64'hFFFFFFD6);
        checkEq("smul_noise_div0", 64'(div0), 64'd0);
        @(posedge clk); #1;
        checkEq("smul_done_pulse", 64'(done), 64'd0);
        checkEq("smul_noise_idle", 64'(busy), 64'd0);

        runOp(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0, edges, busyLow);
        checkEq("sdiv_lo", 64'(lo), 64'hFFFFFFFD);
        checkEq("sdiv_hi", 64'(hi), 64'hFFFFFFFF);
        checkEq("sdiv_lat", 64'(edges), 64'd33);

        runOp(1'b1, 1'b0, 32'd100, 32'd7, 0, edges, busyLow);
        checkEq("udiv_lo", 64'(lo), 64'd14);
        checkEq("udiv_hi", 64'(hi), 64'd2);

        // Divide by zero: immediate done, results held, never busy.
        start = 1'b1; op = 1'b1; sgn = 1'b0; a = 32'd5; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checkEq("dz_done", 64'(done), 64'd1);
        checkEq("dz_div0", 64'(div0), 64'd1);
        checkEq("dz_busy", 64'(busy), 64'd0);
        checkEq("dz_hi", 64'(hi), 64'd2);
        checkEq("dz_lo", 64'(lo), 64'd14);
        @(posedge clk); #1;
        checkEq("dz_done_clr", 64'(done), 64'd0);
        checkEq("dz_div0_hold", 64'(div0), 64'd1);
        checkEq("dz_busy2", 64'(busy), 64'd0);

        runOp(1'b0, 1'b0, 32'd3, 32'd1, 0, edges, busyLow);
        checkEq("early_div0_clr", 64'(div0), 64'd0);
        checkEq("early_hi", 64'(hi), 64'd0);
        checkEq("early_lo", 64'(lo), 64'd3);
        checkEq("early_lat", 64'(edges), 64'(earlyLat));

        runOp(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, edges, busyLow);
        checkEq("minneg_lo", 64'(lo), 64'h80000000);
        checkEq("minneg_hi", 64'(hi), 64'd0);
        checkEq("minneg_div0", 64'(div0), 64'd0);

        runOp(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 0, edges, busyLow);
        checkEq("udiv_big_lo", 64'(lo), 64'h7FFFFFFC);
        checkEq("udiv_big_hi", 64'(hi), 64'd1);

        runOp(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 0, edges, busyLow);
        checkEq("sdiv_negb_lo", 64'(lo), 64'hFFFFFFFD);
        checkEq("sdiv_negb_hi", 64'(hi), 64'd1);

        // Reset during iteration 10 discards the operation.
        start = 1'b1; op = 1'b0; sgn = 1'b0; a = 32'd5; b = 32'hFFFF0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkEq("midrst_busy", 64'(busy), 64'd0);
        checkEq("midrst_done", 64'(done), 64'd0);
        checkEq("midrst_div0", 64'(div0), 64'd0);
        checkEq("midrst_hi", 64'(hi), 64'd0);
        checkEq("midrst_lo", 64'(lo), 64'd0);
        #2 reset = 1'b1;

        runOp(1'b0, 1'b1, 32'd3, 32'hFFFFFFFE, 0, edges, busyLow);
        checkEq("post_rst_hi", 64'(hi), 64'hFFFFFFFF);
        checkEq("post_rst_lo", 64'(lo), 64'hFFFFFFFA);
        checkEq("post_rst_busy", 64'(busyLow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
